hazard_stall_controller: RTL and testbench

- Sequencing controller for the ARM 5-stage pipeline's operand-bypass path; sits beside the forwarding unit in the ID stage.
- Keeps its own shadow scoreboard of destination tags for the EXE/MEM/WB stages.
- Decides each cycle whether the ID instruction issues, stalls (bubble into EXE), or the whole pipe freezes for memory wait; applies flushes on taken branches.
- Owns the forwarding-enable policy: the mode change is applied only when in-flight writers have drained. Counts stall cycles for performance monitoring.

---
 rtl/hazard_stall_controller_pkg.sv | 20 ++
 rtl/hazard_stall_controller_scoreboard.sv | 65 ++++++
 rtl/hazard_stall_controller.sv | 104 ++++++++++
 tb/tb_hazard_stall_controller.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_controller_pkg.sv
// Shared definitions for the ID-stage hazard/stall controller: FSM states,
// scoreboard slot indices and the forwarding-select codes used by the bypass mux.
package hazard_stall_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MEMW  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int unsigned SLOT_EXE  = 0;
    localparam int unsigned SLOT_MEM  = 1;
    localparam int unsigned SLOT_WB   = 2;
    localparam int unsigned NUM_SLOTS = 3;

    localparam logic [1:0] FORW_SEL_ID  = 2'd0;
    localparam logic [1:0] FORW_SEL_MEM = 2'd1;
    localparam logic [1:0] FORW_SEL_WB  = 2'd2;

endpackage

// File: rtl/hazard_stall_controller_scoreboard.sv
// Shadow scoreboard of destination tags for EXE/MEM/WB plus the source-match
// comparators that produce the raw data-hazard indication.
module hazard_scoreboard
    import hazard_stall_controller_pkg::*;
#(
    parameter int unsigned REG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic             issue,
    input  logic             en_forwarding,
    input  logic             id_wb_en,
    input  logic             id_mem_read,
    input  logic [REG_W-1:0] id_dst,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_use_src1,
    input  logic             id_use_src2,
    output logic             hazard,
    output logic             exe_valid,
    output logic             mem_valid,
    output logic             wb_valid
);

    logic [NUM_SLOTS-1:0] slot_valid;
    logic                 exe_wb_en, exe_mem_read, mem_wb_en;
    logic [REG_W-1:0]     exe_dst, mem_dst;
    logic                 exe_hit, mem_hit;

    // Load flag matters only in EXE and WB never hazards (register file writes on
    // the falling edge), so later slots keep just the fields the comparators read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid   <= '0;
            exe_wb_en    <= 1'b0;
            exe_mem_read <= 1'b0;
            exe_dst      <= '0;
            mem_wb_en    <= 1'b0;
            mem_dst      <= '0;
        end else if (advance) begin
            slot_valid[SLOT_EXE] <= issue;
            slot_valid[SLOT_MEM] <= slot_valid[SLOT_EXE];
            slot_valid[SLOT_WB]  <= slot_valid[SLOT_MEM];
            exe_wb_en            <= id_wb_en;
            exe_mem_read         <= id_mem_read;
            exe_dst              <= id_dst;
            mem_wb_en            <= exe_wb_en;
            mem_dst              <= exe_dst;
        end
    end

    always_comb begin
        exe_hit = slot_valid[SLOT_EXE] & exe_wb_en &
                  ((id_use_src1 & (exe_dst == id_src1)) | (id_use_src2 & (exe_dst == id_src2)));
        mem_hit = slot_valid[SLOT_MEM] & mem_wb_en &
                  ((id_use_src1 & (mem_dst == id_src1)) | (id_use_src2 & (mem_dst == id_src2)));
        hazard  = en_forwarding ? (exe_hit & exe_mem_read) : (exe_hit | mem_hit);
    end

    assign exe_valid = slot_valid[SLOT_EXE];
    assign mem_valid = slot_valid[SLOT_MEM];
    assign wb_valid  = slot_valid[SLOT_WB];

endmodule

// File: rtl/hazard_stall_controller.sv
// ID-stage sequencing controller: issue/stall/freeze/flush decisions, forwarding
// mode changes after in-flight writers drain, and a saturating stall counter.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int unsigned REG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fwd_mode_req,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_use_src1,
    input  logic             id_use_src2,
    input  logic             id_wb_en,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_mem_read,
    input  logic             exe_branch_taken,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             en_forwarding,
    output logic             freeze_if_id,
    output logic             bubble_id_ex,
    output logic             freeze_all,
    output logic             flush,
    output logic [CNT_W-1:0] stall_count
);

    state_t state, state_nxt;
    logic   hazard, exe_valid, mem_valid, wb_valid;
    logic   issue, drain_busy, mode_apply;

    hazard_scoreboard #(.REG_W(REG_W)) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .advance       (~freeze_all),
        .issue         (issue),
        .en_forwarding (en_forwarding),
        .id_wb_en      (id_wb_en),
        .id_mem_read   (id_mem_read),
        .id_dst        (id_dst),
        .id_src1       (id_src1),
        .id_src2       (id_src2),
        .id_use_src1   (id_use_src1),
        .id_use_src2   (id_use_src2),
        .hazard        (hazard),
        .exe_valid     (exe_valid),
        .mem_valid     (mem_valid),
        .wb_valid      (wb_valid)
    );

    always_comb begin
        freeze_all   = ~mem_ready;
        flush        = exe_branch_taken & ~freeze_all;
        drain_busy   = exe_valid | mem_valid | wb_valid;
        freeze_if_id = 1'b0;
        if (!freeze_all && !flush)
            freeze_if_id = (state == ST_DRAIN) ? drain_busy : hazard;
        bubble_id_ex = freeze_if_id;
        issue        = id_valid & ~freeze_if_id & ~flush;
        mode_apply   = 1'b0;
        state_nxt    = state;
        case (state)
            ST_RUN: begin
                if (freeze_all)
                    state_nxt = ST_MEMW;
                else if (fwd_mode_req != en_forwarding)
                    state_nxt = ST_DRAIN;
            end
            ST_MEMW: begin
                if (!freeze_all)
                    state_nxt = ST_RUN;
            end
            ST_DRAIN: begin
                // EXE and MEM empty: the edge shifts out the last writer and loads a
                // bubble or nothing-dependent issue, so the mode can switch now.
                if (!freeze_all && !exe_valid && !mem_valid) begin
                    mode_apply = 1'b1;
                    state_nxt  = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_RUN;
            en_forwarding <= 1'b0;
            stall_count   <= '0;
        end else begin
            state <= state_nxt;
            if (mode_apply)
                en_forwarding <= fwd_mode_req;
            if (cnt_clr)
                stall_count <= '0;
            else if (freeze_if_id && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed and randomized checks of hazard_stall_controller against a
// per-instruction age model of the pipeline.
module tb_hazard_stall_controller;

    localparam int unsigned RW   = 4;
    localparam int unsigned CW   = 10;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fwd_mode_req, id_valid, id_use_src1, id_use_src2, id_wb_en, id_mem_read;
    logic [RW-1:0] id_src1, id_src2, id_dst;
    logic          exe_branch_taken, mem_ready, cnt_clr;
    logic          en_forwarding, freeze_if_id, bubble_id_ex, freeze_all, flush;
    logic [CW-1:0] stall_count;

    always #5 clk = ~clk;

    hazard_stall_controller #(.REG_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .fwd_mode_req(fwd_mode_req), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_use_src1(id_use_src1),
        .id_use_src2(id_use_src2), .id_wb_en(id_wb_en), .id_dst(id_dst),
        .id_mem_read(id_mem_read), .exe_branch_taken(exe_branch_taken),
        .mem_ready(mem_ready), .cnt_clr(cnt_clr), .en_forwarding(en_forwarding),
        .freeze_if_id(freeze_if_id), .bubble_id_ex(bubble_id_ex),
        .freeze_all(freeze_all), .flush(flush), .stall_count(stall_count)
    );

    // Reference model: every issued instruction carries its age in advancing edges
    // (0 = EXE, 1 = MEM, 2 = WB) and leaves the list after WB.
    typedef struct {
        bit          wb;
        bit          ld;
        int unsigned dst;
        int unsigned age;
    } rec_t;

    rec_t q[$];
    bit   m_mode, m_drain, m_wait;
    int   m_cnt;
    bit   m_frz, m_fl, m_hz, m_stall;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_mode  = 1'b0;
        m_drain = 1'b0;
        m_wait  = 1'b0;
        m_cnt   = 0;
    endfunction

    function automatic void model_eval();
        bit reads;
        m_frz = !mem_ready;
        m_fl  = exe_branch_taken && !m_frz;
        m_hz  = 1'b0;
        foreach (q[i]) begin
            reads = (id_use_src1 && q[i].dst == int'(id_src1)) ||
                    (id_use_src2 && q[i].dst == int'(id_src2));
            if (q[i].wb && reads) begin
                if (q[i].age == 0 && (!m_mode || q[i].ld)) m_hz = 1'b1;
                if (q[i].age == 1 && !m_mode)              m_hz = 1'b1;
            end
        end
        m_stall = !m_frz && !m_fl && (m_drain ? (q.size() > 0) : m_hz);
    endfunction

    function automatic void model_edge();
        bit   young_writer = 1'b0;
        rec_t r;
        if (!m_frz) begin
            foreach (q[i]) if (q[i].age <= 1) young_writer = 1'b1;
            foreach (q[i]) q[i].age++;
            for (int i = q.size() - 1; i >= 0; i--) if (q[i].age > 2) q.delete(i);
            if (id_valid && !m_stall && !m_fl) begin
                r.wb = id_wb_en; r.ld = id_mem_read; r.dst = int'(id_dst); r.age = 0;
                q.push_back(r);
            end
        end
        if (m_drain) begin
            if (!m_frz && !young_writer) begin
                m_mode  = fwd_mode_req;
                m_drain = 1'b0;
            end
        end else if (m_wait) begin
            if (!m_frz) m_wait = 1'b0;
        end else if (m_frz) begin
            m_wait = 1'b1;
        end else if (fwd_mode_req != m_mode) begin
            m_drain = 1'b1;
        end
        if (cnt_clr)                       m_cnt = 0;
        else if (m_stall && m_cnt < CMAX)  m_cnt++;
    endfunction

    // Inputs are driven just after a rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
        model_eval();
        chk("freeze_all",    32'(freeze_all),    32'(m_frz));
        chk("flush",         32'(flush),         32'(m_fl));
        chk("freeze_if_id",  32'(freeze_if_id),  32'(m_stall));
        chk("bubble_id_ex",  32'(bubble_id_ex),  32'(m_stall));
        chk("en_forwarding", 32'(en_forwarding), 32'(m_mode));
        chk("stall_count",   32'(stall_count),   32'(m_cnt));
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic drv(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                       input bit wb, input int dst, input bit ld);
        id_valid = v; id_src1 = RW'(s1); id_use_src1 = u1; id_src2 = RW'(s2);
        id_use_src2 = u2; id_wb_en = wb; id_dst = RW'(dst); id_mem_read = ld;
    endtask

    task automatic clr_step();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; fwd_mode_req = 1'b0; exe_branch_taken = 1'b0;
        mem_ready = 1'b1; cnt_clr = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        chk("rst_freeze_if_id", 32'(freeze_if_id), 0);
        chk("rst_bubble",       32'(bubble_id_ex), 0);
        chk("rst_freeze_all",   32'(freeze_all), 0);
        chk("rst_flush",        32'(flush), 0);
        chk("rst_en_fwd",       32'(en_forwarding), 0);
        chk("rst_count",        32'(stall_count), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Forwarding off: ADD R5 then a reader of R5 via src2 -> 2 stalls.
        drv(1, 0, 0, 0, 0, 1, 5, 0); step();
        drv(1, 0, 0, 5, 1, 0, 0, 0);
        #1 chk("fwdoff_stall1", 32'(freeze_if_id), 1); step();
        #1 chk("fwdoff_stall2", 32'(freeze_if_id), 1); step();
        #1 chk("fwdoff_issue",  32'(freeze_if_id), 0); step();
        drv(0, 0, 0, 0, 0, 0, 0, 0); step();
        chk("fwdoff_count", 32'(stall_count), 2);

        // Mode 0->1 requested with three writers in flight -> 3 drain bubbles.
        clr_step();
        drv(1, 0, 0, 0, 0, 1, 1, 0); step();
        drv(1, 0, 0, 0, 0, 1, 2, 0); step();
        fwd_mode_req = 1'b1;
        drv(1, 0, 0, 0, 0, 1, 3, 0); step();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("drain_bubble", 32'(bubble_id_ex), 1);
            chk("drain_mode_old", 32'(en_forwarding), 0);
            step();
        end
        chk("drain_mode_new", 32'(en_forwarding), 1);
        chk("drain_count", 32'(stall_count), 3);

        // Forwarding on: load-use costs one stall; ALU dependency costs none.
        clr_step();
        drv(1, 0, 0, 0, 0, 1, 3, 1); step();
        drv(1, 3, 1, 0, 0, 0, 0, 0);
        #1 chk("lu_stall", 32'(freeze_if_id), 1); step();
        #1 chk("lu_issue", 32'(freeze_if_id), 0); step();
        drv(0, 0, 0, 0, 0, 0, 0, 0); step();
        chk("lu_count", 32'(stall_count), 1);
        clr_step();
        drv(1, 0, 0, 0, 0, 1, 5, 0); step();
        drv(1, 0, 0, 5, 1, 0, 0, 0);
        #1 chk("fwdon_nostall", 32'(freeze_if_id), 0); step();
        drv(0, 0, 0, 0, 0, 0, 0, 0); step();
        chk("fwdon_count", 32'(stall_count), 0);

        // Memory wait over a pending load-use: freeze 3 cycles, then the stall remains.
        clr_step();
        drv(1, 0, 0, 0, 0, 1, 3, 1); step();
        drv(1, 3, 1, 0, 0, 0, 0, 0);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("memw_freeze_all", 32'(freeze_all), 1);
            chk("memw_no_stall", 32'(freeze_if_id), 0);
            step();
        end
        chk("memw_count_held", 32'(stall_count), 0);
        mem_ready = 1'b1;
        #1 chk("memw_lu_stall", 32'(freeze_if_id), 1); step();
        #1 chk("memw_lu_issue", 32'(freeze_if_id), 0); step();
        drv(0, 0, 0, 0, 0, 0, 0, 0); step();
        chk("memw_count", 32'(stall_count), 1);

        // Taken branch coincident with a load-use hazard: flush wins.
        clr_step();
        drv(1, 0, 0, 0, 0, 1, 3, 1); step();
        drv(1, 3, 1, 0, 0, 0, 0, 0);
        exe_branch_taken = 1'b1;
        #1 chk("br_flush", 32'(flush), 1);
        chk("br_no_freeze", 32'(freeze_if_id), 0);
        chk("br_no_bubble", 32'(bubble_id_ex), 0);
        step();
        exe_branch_taken = 1'b0;
        #1 chk("br_exe_empty", 32'(freeze_if_id), 0); step();
        drv(0, 0, 0, 0, 0, 0, 0, 0); step();
        chk("br_count", 32'(stall_count), 0);

        // Back to forwarding off, then saturate the counter with a self-dependent ADD.
        fwd_mode_req = 1'b0;
        for (int i = 0; i < 10 && m_mode; i++) step();
        chk("mode_off", 32'(en_forwarding), 0);
        clr_step();
        drv(1, 1, 1, 0, 0, 1, 1, 0);
        repeat (1650) step();
        chk("sat_count", 32'(stall_count), CMAX);
        for (int i = 0; i < 5; i++) begin
            model_eval();
            if (m_stall) break;
            step();
        end
        cnt_clr = 1'b1;
        #1 chk("clr_during_stall", 32'(freeze_if_id), 1);
        step();
        cnt_clr = 1'b0;
        chk("clr_count", 32'(stall_count), 0);

        // Randomized traffic over a small register range.
        for (int i = 0; i < 600; i++) begin
            drv(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0));
            mem_ready        = ($urandom_range(0, 4) != 0);
            exe_branch_taken = ($urandom_range(0, 9) == 0);
            cnt_clr          = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 39) == 0) fwd_mode_req = ~fwd_mode_req;
            step();
        end

        // Asynchronous reset in the middle of a drain.
        mem_ready = 1'b1; exe_branch_taken = 1'b0; cnt_clr = 1'b0; fwd_mode_req = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12 && (!m_mode || m_drain); i++) step();
        chk("mode_on", 32'(en_forwarding), 1);
        fwd_mode_req = 1'b0;
        drv(1, 0, 0, 0, 0, 1, 7, 0); step();
        drv(0, 0, 0, 0, 0, 0, 0, 0); step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_freeze_if_id", 32'(freeze_if_id), 0);
        chk("arst_bubble",       32'(bubble_id_ex), 0);
        chk("arst_freeze_all",   32'(freeze_all), 0);
        chk("arst_flush",        32'(flush), 0);
        chk("arst_en_fwd",       32'(en_forwarding), 0);
        chk("arst_count",        32'(stall_count), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
